// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request-side and UART-side signals of the UART transmit arbiter
interface uart_tx_arbiter_if;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_last;
  logic [3:0]  o_req_ready;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;
  logic [1:0]  o_grant;
  logic        o_active;
  logic        o_timeout;
  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_busy,
    input  o_req_ready, o_tx_start, o_tx_data, o_grant, o_active, o_timeout
  );
  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_busy,
    output o_req_ready, o_tx_start, o_tx_data, o_grant, o_active, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-granular round-robin arbiter feeding four byte streams into one UART transmitter
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic i_clk,
  input logic i_rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, FETCH, START, DRAIN} state_t;
  state_t state;
  logic [1:0] rr_ptr, pick;
  logic last_q;
  logic [CW-1:0] cnt;
  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    pick = rr_ptr;
    for (int i = 3; i >= 0; i--)
      if (bus.i_req_valid[rr_ptr + 2'(i)]) pick = rr_ptr + 2'(i);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      bus.o_grant <= '0;
      bus.o_req_ready <= '0;
      bus.o_tx_start <= 1'b0;
      bus.o_tx_data <= '0;
      bus.o_active <= 1'b0;
      bus.o_timeout <= 1'b0;
      last_q <= 1'b0;
      cnt <= '0;
    end else begin
      bus.o_timeout <= 1'b0;
      case (state)
        IDLE: if (|bus.i_req_valid) begin
          bus.o_grant <= pick;
          bus.o_req_ready <= 4'b1 << pick;
          bus.o_active <= 1'b1;
          state <= FETCH;
        end
        FETCH: if (bus.i_req_valid[bus.o_grant]) begin
          bus.o_tx_data <= bus.i_req_data[{bus.o_grant, 3'b0} +: 8];
          last_q <= bus.i_req_last[bus.o_grant];
          bus.o_req_ready <= '0;
          bus.o_tx_start <= 1'b1;
          cnt <= '0;
          state <= START;
        end
        START: if (bus.i_tx_busy) begin
          bus.o_tx_start <= 1'b0;
          state <= DRAIN;
        end else if (cnt == TMAX) begin
          bus.o_tx_start <= 1'b0;
          bus.o_timeout <= 1'b1;
          bus.o_active <= 1'b0;
          rr_ptr <= bus.o_grant + 2'd1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        DRAIN: if (!bus.i_tx_busy) begin
          if (last_q) begin
            bus.o_active <= 1'b0;
            rr_ptr <= bus.o_grant + 2'd1;
            state <= IDLE;
          end else begin
            bus.o_req_ready <= 4'b1 << bus.o_grant;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: cycle table plus directed multi-cycle sequences for the UART transmit arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic model_en = 1'b0, busy_drv = 1'b0, mb = 1'b0;
  int mc = 0;
  int checks = 0, errors = 0;
  uart_tx_arbiter_if bus();
  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.i_tx_busy = model_en ? mb : busy_drv;
  // transmitter model: busy rises 3 cycles after start, stays high 20 cycles
  always @(posedge clk) begin
    if (!model_en) begin
      mb <= 1'b0;
      mc <= 0;
    end else if (mb) begin
      if (mc == 19) begin
        mb <= 1'b0;
        mc <= 0;
      end else mc <= mc + 1;
    end else if (bus.o_tx_start) begin
      if (mc == 2) begin
        mb <= 1'b1;
        mc <= 0;
      end else mc <= mc + 1;
    end else mc <= 0;
  end
  typedef struct packed {
    logic rst;
    logic [3:0] v;
    logic [3:0] l;
    logic [31:0] d;
    logic b;
    logic [3:0] rdy;
    logic st;
    logic [1:0] g;
    logic act;
    logic to;
    logic [7:0] td;
  } vec_t;
  vec_t tv[17];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask
  task automatic tick(output logic x);
    x = |(bus.o_req_ready & bus.i_req_valid);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    logic x;
    rst = 1'b1;
    model_en = 1'b0;
    busy_drv = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_last = '0;
    bus.i_req_data = '0;
    tick(x);
    rst = 1'b0;
  endtask
  initial begin
    logic x, done, seen, prev, got, hit;
    int nb, ns, nst, nto, bad;
    logic [7:0] sd[2];
    logic [31:0] d0;
    d0 = 32'h44115522;
    tv[0]  = '{1'b1, 4'h0, 4'h0, d0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 4'h0, 4'h0, d0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{1'b0, 4'h4, 4'h4, d0, 1'b0, 4'h4, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00};
    tv[3]  = '{1'b0, 4'h4, 4'h4, d0, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h11};
    tv[4]  = '{1'b0, 4'h0, 4'h0, d0, 1'b1, 4'h0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h11};
    tv[5]  = '{1'b0, 4'h0, 4'h0, d0, 1'b1, 4'h0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h11};
    tv[6]  = '{1'b0, 4'h0, 4'h0, d0, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0, 8'h11};
    tv[7]  = '{1'b0, 4'h3, 4'h0, d0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h11};
    tv[8]  = '{1'b0, 4'h3, 4'h0, d0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 8'h22};
    tv[9]  = '{1'b0, 4'h0, 4'h0, d0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h22};
    tv[10] = '{1'b0, 4'h0, 4'h0, d0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h22};
    tv[11] = '{1'b0, 4'h2, 4'h0, d0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h22};
    tv[12] = '{1'b0, 4'h1, 4'h1, 32'h44115533, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 8'h33};
    tv[13] = '{1'b0, 4'h0, 4'h0, d0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 8'h33};
    tv[14] = '{1'b0, 4'h0, 4'h0, d0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h33};
    tv[15] = '{1'b0, 4'h0, 4'h0, d0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h33};
    tv[16] = '{1'b0, 4'h9, 4'h0, d0, 1'b0, 4'h8, 1'b0, 2'd3, 1'b1, 1'b0, 8'h33};
    for (int i = 0; i < 17; i++) begin
      rst = tv[i].rst;
      bus.i_req_valid = tv[i].v;
      bus.i_req_last = tv[i].l;
      bus.i_req_data = tv[i].d;
      busy_drv = tv[i].b;
      tick(x);
      chk($sformatf("row%0d", i),
          {bus.o_req_ready, bus.o_tx_start, bus.o_grant, bus.o_active, bus.o_timeout, bus.o_tx_data},
          {tv[i].rdy, tv[i].st, tv[i].g, tv[i].act, tv[i].to, tv[i].td});
    end
    // two-byte frame from requester 1 through the busy model
    do_reset();
    model_en = 1'b1;
    bus.i_req_valid = 4'b0010;
    bus.i_req_data = 32'h00004800;
    nb = 0; ns = 0; prev = 1'b0; seen = 1'b0; done = 1'b0;
    sd[0] = '0; sd[1] = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick(x);
      if (x) begin
        nb++;
        if (nb == 1) begin
          bus.i_req_data = 32'h00006900;
          bus.i_req_last = 4'b0010;
        end else bus.i_req_valid = '0;
      end
      if (bus.o_tx_start && !prev) begin
        if (ns < 2) sd[ns] = bus.o_tx_data;
        ns++;
      end
      prev = bus.o_tx_start;
      if (bus.o_active) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk("a_done", 32'(done), 1);
    chk("a_starts", ns, 2);
    chk("a_byte0", 32'(sd[0]), 32'h48);
    chk("a_byte1", 32'(sd[1]), 32'h69);
    // round robin hands over to requester 2 even though requester 0 re-offers
    do_reset();
    model_en = 1'b1;
    bus.i_req_valid = 4'b0101;
    bus.i_req_data = 32'h00C200A0;
    bus.i_req_last = 4'b0101;
    tick(x);
    chk("b_first_grant", 32'(bus.o_grant), 0);
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick(x);
      if (!bus.o_active) done = 1'b1;
    end
    chk("b_done", 32'(done), 1);
    tick(x);
    chk("b_second_grant", 32'(bus.o_grant), 2);
    // requester 3 stalls mid-frame while requester 0 waits
    do_reset();
    model_en = 1'b1;
    bus.i_req_valid = 4'b1000;
    bus.i_req_data = 32'hAA000000;
    tick(x);
    chk("c_grant", 32'(bus.o_grant), 3);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick(x);
      if (x) got = 1'b1;
    end
    chk("c_xfer0", 32'(got), 1);
    bus.i_req_valid = 4'b0001;
    bus.i_req_data = 32'hAA000001;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick(x);
      if (bus.o_grant != 2'd3 || bus.o_req_ready[0]) bad++;
    end
    chk("c_hold", bad, 0);
    bus.i_req_valid = 4'b1001;
    bus.i_req_data = 32'hBB000001;
    bus.i_req_last = 4'b1000;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      tick(x);
      if (x) got = 1'b1;
    end
    chk("c_xfer1", 32'(got), 1);
    chk("c_data1", 32'(bus.o_tx_data), 32'hBB);
    bus.i_req_valid = 4'b0001;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick(x);
      if (!bus.o_active) done = 1'b1;
    end
    chk("c_done", 32'(done), 1);
    tick(x);
    chk("c_next_grant", 32'(bus.o_grant), 0);
    // start timeout with the transmitter never going busy
    do_reset();
    bus.i_req_valid = 4'b0010;
    bus.i_req_last = 4'b0010;
    bus.i_req_data = 32'h00005A00;
    nst = 0; nto = 0;
    for (int c = 0; c < 40; c++) begin
      tick(x);
      if (x) bus.i_req_valid = '0;
      nst += int'(bus.o_tx_start);
      nto += int'(bus.o_timeout);
    end
    chk("d_start_cycles", nst, 16);
    chk("d_timeout_pulses", nto, 1);
    chk("d_idle", 32'(bus.o_active), 0);
    bus.i_req_valid = 4'b0110;
    tick(x);
    chk("d_rr_advanced", 32'(bus.o_grant), 2);
    // reset during the drain of the second byte of a three-byte frame
    do_reset();
    model_en = 1'b1;
    bus.i_req_valid = 4'b0100;
    bus.i_req_data = 32'h00010000;
    nb = 0; hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      tick(x);
      if (x) begin
        nb++;
        bus.i_req_data = {8'h00, 8'(nb + 1), 16'h0000};
        if (nb == 2) bus.i_req_last = 4'b0100;
        if (nb == 3) bus.i_req_valid = '0;
      end
      if (nb == 2 && bus.o_active && !bus.o_tx_start && bus.i_tx_busy) hit = 1'b1;
    end
    chk("e_in_drain", 32'(hit), 1);
    rst = 1'b1;
    model_en = 1'b0;
    tick(x);
    chk("e_reset_outputs",
        {bus.o_req_ready, bus.o_tx_start, bus.o_grant, bus.o_active, bus.o_timeout, bus.o_tx_data}, 0);
    rst = 1'b0;
    bus.i_req_valid = 4'b1010;
    tick(x);
    chk("e_post_reset_grant", 32'(bus.o_grant), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1_000_000, max i_clk cycles to wait for i_tx_busy to rise after o_tx_start asserts.
REQ-002 i_clk  input  1  clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req_valid  input  4  per-requester byte valid.
REQ-005 i_req_data  input  32  per-requester byte; requester k on bits [8k+7:8k].
REQ-006 i_req_last  input  4  per-requester end-of-frame flag, qualified by valid.
REQ-007 o_req_ready  output  4  per-requester byte accept; a byte transfers when valid&&ready in the same cycle.
REQ-008 o_tx_start  output  1  start request to the UART transmitter.
REQ-009 o_tx_data  output  8  byte to the UART transmitter.
REQ-010 i_tx_busy  input  1  busy from the UART transmitter.
REQ-011 o_grant  output  2  index of the current or most recent granted requester.
REQ-012 o_active  output  1  high while a frame is owned (any state but IDLE).
REQ-013 o_timeout  output  1  one-cycle pulse when a start timeout occurs.

Function
REQ-014 FSM states: IDLE, FETCH, START, DRAIN; registered, one transition per cycle maximum.
REQ-015 IDLE: if any i_req_valid set, register o_grant = first valid requester in round-robin order beginning at rr_ptr, then go to FETCH; otherwise stay.
REQ-016 rr_ptr resets to 0 (priority 0,1,2,3); on frame end or timeout it becomes (o_grant+1) mod 4.
REQ-017 o_req_ready is Moore: o_req_ready[o_grant]=1 only in FETCH; all other bits always 0.
REQ-018 FETCH: on i_req_valid[o_grant], capture byte into o_tx_data and last flag into last_q, go to START; if valid is low, stay in FETCH indefinitely with grant held.
REQ-019 Grant is frame-granular: no other requester is served until the byte with last=1 has drained or a timeout occurs.
REQ-020 START: o_tx_start=1; when i_tx_busy=1, go to DRAIN.
REQ-021 DRAIN: o_tx_start=0; when i_tx_busy=0, go to IDLE if last_q=1, else to FETCH.
REQ-022 o_tx_data holds stable from the FETCH capture until the DRAIN exit; it changes only on FETCH capture.
REQ-023 o_tx_start is registered and high only in START; each byte yields exactly one start assertion interval.
REQ-024 Timeout counter: cleared on START entry, increments each START cycle; at TIMEOUT_CYCLES-1 without busy, pulse o_timeout, drop o_tx_start, abandon the frame, advance rr_ptr, go to IDLE.
REQ-025 Timeout counter width is $clog2(TIMEOUT_CYCLES)+1; the counter never wraps.
REQ-026 If i_tx_busy is already 1 on START entry, the transition to DRAIN occurs on the next edge.
REQ-027 Single-byte frame (last=1 on first byte): FETCH, START, DRAIN, IDLE.
REQ-028 A valid that deasserts on a non-granted requester before grant has no effect; no byte is lost or duplicated on the granted requester.

Reset
REQ-029 On i_rst: state=IDLE, rr_ptr=0, o_grant=0, o_req_ready=0, o_tx_start=0, o_tx_data=0, o_active=0, o_timeout=0, last_q=0, timeout counter=0.
REQ-030 Reset mid-frame abandons the frame; the first post-reset grant follows REQ-015 with rr_ptr=0.

Verification
REQ-031 Req1 sends 0x48,0x69(last); busy model rises 3 cycles after start, holds 20 cycles -> o_tx_data 0x48 then 0x69, one start interval each, o_active falls after the second drain.
REQ-032 Req0 and req2 both valid in IDLE after reset -> req0 granted first; after its last byte, req2 granted even if req0 is valid again.
REQ-033 Req3 granted, frame 0xAA,0xBB(last), req3 valid low for 50 cycles between bytes while req0 valid -> grant stays 3, req0 ready stays 0.
REQ-034 TIMEOUT_CYCLES=16, busy tied 0 -> o_tx_start high exactly 16 cycles, o_timeout one-cycle pulse, state IDLE, rr_ptr advanced.
REQ-035 Assert i_rst during DRAIN of a 3-byte frame -> next cycle all outputs at reset values; a post-reset request is served from rr_ptr=0.
REQ-036 Busy already high on START entry -> DRAIN entered next cycle; the byte is not re-sent.
